random_delay: RTL and testbench
===============================

RANDOM_DELAY -- requirements
Module: random_delay

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clock cycles per delay tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter MIN_DELAY, default 1000, meaning the lower clamp in ticks.
REQ-003 SHALL have parameter MAX_DELAY, default 5000, meaning the upper clamp in ticks.
REQ-004 SHALL have port clk, input, width 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, width 1: request to begin one random delay.
REQ-007 SHALL have port cancel, input, width 1: abort the delay in progress.
REQ-008 SHALL have port random_value, input, width 18: value from the RNG counter.
REQ-009 SHALL have port change, output, width 1: one-cycle pulse asking the RNG to advance.
REQ-010 SHALL have port busy, output, width 1: high in REQ, LATCH and COUNT.
REQ-011 SHALL have port done, output, width 1: one-cycle pulse when the delay expires.
REQ-012 SHALL have port delay_value, output, width 18: the latched (clamped) delay in ticks.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, LATCH, COUNT and DONE; all outputs SHALL be registered.
REQ-014 SHALL move from IDLE to REQ on the edge where start=1 (cycle 0); change=1 only while in REQ (cycle 1).
REQ-015 SHALL move from REQ to LATCH unconditionally; on exit from LATCH (cycle 2) it SHALL capture random_value into delay_value and the remaining-tick counter.
REQ-016 SHALL enter COUNT at cycle 3 with the tick divider cleared; each TICK_DIV cycles in COUNT SHALL decrement the remaining count by 1.
REQ-017 SHALL go from COUNT to DONE when the remaining count reaches 0, giving done=1 at cycle 3+N*TICK_DIV for latched value N.
REQ-018 SHALL, for latched N=0, go LATCH to DONE directly, so done=1 at cycle 3.
REQ-019 SHALL go from DONE to IDLE after one cycle; start sampled in DONE SHALL be ignored.
REQ-020 SHALL ignore start whenever busy=1; there is no queuing.
REQ-021 SHALL, on cancel=1 in REQ, LATCH or COUNT, go to IDLE next cycle with no done pulse; delay_value SHALL hold its last value.
REQ-022 SHALL give cancel priority when cancel and expiry occur on the same edge (no done); cancel in IDLE or DONE SHALL have no effect.
REQ-023 SHALL saturate the tick divider width at clog2(TICK_DIV); the remaining counter SHALL be 18 bits and SHALL never wrap below 0.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, set the state to IDLE, change=0, busy=0, done=0, delay_value=0, and clear both counters.
REQ-025 SHALL give reset priority over start and cancel, including mid-COUNT, with no done pulse emitted.

Configuration
REQ-026 SHALL, when RANDOM_DELAY_CLAMP_EN is defined, latch min(max(random_value, MIN_DELAY), MAX_DELAY).
REQ-027 SHALL, when RANDOM_DELAY_CLAMP_EN is undefined, latch random_value unmodified, and MIN_DELAY and MAX_DELAY SHALL be unused.

Structure
REQ-028 SHALL take the state enum typedef and the constant RNG_WIDTH=18 from the shared package rng_pkg.
REQ-029 SHALL place the TICK_DIV prescaler in sub-module tick_divider (clk, reset, clear, enable -> tick pulse).

Verification (TICK_DIV=4, MIN_DELAY=2, MAX_DELAY=6 for sim)
REQ-030 SHALL cover basic delay, clamp off: start at cycle 0 with random_value=3 -> change=1 at cycle 1, delay_value=3, done=1 at cycle 15 only.
REQ-031 SHALL cover zero delay, clamp off: random_value=0 -> done=1 at cycle 3, busy low from cycle 3.
REQ-032 SHALL cover clamping with RANDOM_DELAY_CLAMP_EN: random_value=1 -> delay_value=2, done at cycle 11; random_value=200000 -> delay_value=6, done at cycle 27.
REQ-033 SHALL cover cancel: cancel=1 at cycle 8 of a 3-tick delay -> IDLE at cycle 9, busy=0, no done; a new start then yields a second change pulse.
REQ-034 SHALL cover start while busy: start pulses at cycles 2 and 6 -> exactly one change pulse and one done pulse.
REQ-035 SHALL cover reset mid-COUNT: reset=1 at cycle 6 -> all outputs 0 at cycle 7, no done pulse afterwards.

Source files
------------

// File: rtl/rng_pkg.sv
// -----------------------------------------------------------------------------
// rng_pkg
// Shared definitions for the random delay block and its RNG companion.
//   RNG_WIDTH   : width of the random value / delay counter (18 bits)
//   state_e     : controller states IDLE, REQ, LATCH, COUNT, DONE
//   is_busy     : true for states that report busy
//   clamp_delay : saturates a value into [lo, hi]
// -----------------------------------------------------------------------------
package rng_pkg;

    localparam int RNG_WIDTH = 18;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LATCH = 3'd2,
        COUNT = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic logic is_busy(input state_e s);
        logic b;
        case (s)
            REQ, LATCH, COUNT: b = 1'b1;
            default:           b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic [RNG_WIDTH-1:0] clamp_delay(
        input logic [RNG_WIDTH-1:0] v,
        input logic [RNG_WIDTH-1:0] lo,
        input logic [RNG_WIDTH-1:0] hi
    );
        logic [RNG_WIDTH-1:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, clears the count
//   clear  : synchronous clear, holds the count at zero
//   enable : count while high
//   tick   : high on the last cycle of each TICK_DIV-cycle period
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    // A divide-by-1 still needs a one-bit counter that never leaves zero.
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Next count and tick decode.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = CNT_ZERO;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = CNT_ZERO;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/random_delay.sv
// -----------------------------------------------------------------------------
// random_delay
// Requests a fresh random value, latches it as a delay in ticks of TICK_DIV
// clocks, counts it down and pulses done when it expires.
// Configuration macro: RANDOM_DELAY_CLAMP_EN -- when defined the latched value
// is clamped into [MIN_DELAY, MAX_DELAY]; otherwise it is used unmodified.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   start        : begin one delay (ignored unless idle)
//   cancel       : abort the delay in progress, no done pulse
//   random_value : RNG value, sampled when leaving LATCH
//   change       : one-cycle pulse asking the RNG to advance
//   busy         : high in REQ, LATCH and COUNT
//   done         : one-cycle pulse when the delay expires
//   delay_value  : latched delay in ticks
// -----------------------------------------------------------------------------
module random_delay
    import rng_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int MIN_DELAY = 1000,
    parameter int MAX_DELAY = 5000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cancel,
    input  logic [RNG_WIDTH-1:0] random_value,
    output logic                 change,
    output logic                 busy,
    output logic                 done,
    output logic [RNG_WIDTH-1:0] delay_value
);

    localparam logic [RNG_WIDTH-1:0] VAL_ZERO = {RNG_WIDTH{1'b0}};
    localparam logic [RNG_WIDTH-1:0] VAL_ONE  = {{(RNG_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic                 change_q, change_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RNG_WIDTH-1:0] delay_value_q, delay_value_d;
    logic [RNG_WIDTH-1:0] remaining_q, remaining_d;
    logic [RNG_WIDTH-1:0] latch_value;
    logic                 tick;
    logic                 div_clear;
    logic                 div_enable;

`ifdef RANDOM_DELAY_CLAMP_EN
    localparam logic [RNG_WIDTH-1:0] MIN_V = RNG_WIDTH'(MIN_DELAY);
    localparam logic [RNG_WIDTH-1:0] MAX_V = RNG_WIDTH'(MAX_DELAY);
    assign latch_value = clamp_delay(random_value, MIN_V, MAX_V);
`else
    assign latch_value = random_value;
`endif

    // The divider only runs in COUNT and sits at zero otherwise, so every
    // COUNT entry starts a full tick period.
    assign div_enable = (state_q == COUNT);
    assign div_clear  = (state_q != COUNT);

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk    (clk),
        .reset  (reset),
        .clear  (div_clear),
        .enable (div_enable),
        .tick   (tick)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d       = state_q;
        delay_value_d = delay_value_q;
        remaining_d   = remaining_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    delay_value_d = latch_value;
                    remaining_d   = latch_value;
                    if (latch_value == VAL_ZERO) begin
                        state_d = DONE;
                    end else begin
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                // Cancel wins over an expiry on the same edge.
                if (cancel) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (remaining_q <= VAL_ONE) begin
                        remaining_d = VAL_ZERO;
                        state_d     = DONE;
                    end else begin
                        remaining_d = remaining_q - VAL_ONE;
                    end
                end else begin
                    state_d = COUNT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they register in step
        // with the state they describe.
        change_d = (state_d == REQ);
        busy_d   = is_busy(state_d);
        done_d   = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            change_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            delay_value_q <= VAL_ZERO;
            remaining_q   <= VAL_ZERO;
        end else begin
            state_q       <= state_d;
            change_q      <= change_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            delay_value_q <= delay_value_d;
            remaining_q   <= remaining_d;
        end
    end

    assign change      = change_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign delay_value = delay_value_q;

endmodule

// File: tb/tb_random_delay.sv
// -----------------------------------------------------------------------------
// tb_random_delay
// Scoreboard bench for random_delay (TICK_DIV=4, MIN_DELAY=2, MAX_DELAY=6).
// Cycle c is the clock period after edge c-1; an input driven in cycle c is
// sampled on edge c and registered outputs it causes appear in cycle c+1.
// -----------------------------------------------------------------------------
module tb_random_delay;

    localparam int T     = 4;
    localparam int MIN_D = 2;
    localparam int MAX_D = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [17:0] random_value = 18'd0;
    logic        change;
    logic        busy;
    logic        done;
    logic [17:0] delay_value;

    random_delay #(
        .TICK_DIV  (T),
        .MIN_DELAY (MIN_D),
        .MAX_DELAY (MAX_D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cancel       (cancel),
        .random_value (random_value),
        .change       (change),
        .busy         (busy),
        .done         (done),
        .delay_value  (delay_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t change_q[$];
    ev_t done_q[$];
    ev_t dv_q[$];

    int checks = 0;
    int errors = 0;
    int mon_from = 1 << 30;
    bit end_req = 1'b0;
    bit final_done = 1'b0;

    // Transaction-level model state (written only by the stimulus process).
    int busy_lo = -10;
    int busy_hi = -20;
    int done_at = -1;
    int latch_cyc = -1;

    function automatic int expect_latch(input int rv);
`ifdef RANDOM_DELAY_CLAMP_EN
        if (rv < MIN_D) return MIN_D;
        if (rv > MAX_D) return MAX_D;
`endif
        return rv;
    endfunction

    function automatic void drop_after(input int c);
        while (change_q.size() > 0 && change_q[$].cyc > c) void'(change_q.pop_back());
        while (done_q.size() > 0 && done_q[$].cyc > c) void'(done_q.pop_back());
        while (dv_q.size() > 0 && dv_q[$].cyc > c) void'(dv_q.pop_back());
    endfunction

    // Drive one cycle of inputs and update the expectations they imply.
    task automatic drive(input logic st, input logic cn, input logic rs, input logic [17:0] rv);
        int  c;
        int  n;
        bit  in_busy;
        c       = cyc;
        start        = st;
        cancel       = cn;
        reset        = rs;
        random_value = rv;
        in_busy = (c >= busy_lo) && (c <= busy_hi);
        if (rs) begin
            drop_after(c);
            if (busy_hi > c) busy_hi = c;
            if (done_at > c) done_at = -1;
            latch_cyc = -1;
            dv_q.push_back('{c + 1, 0});
            if (mon_from > c + 1) mon_from = c + 1;
        end else if (cn && in_busy) begin
            drop_after(c);
            busy_hi   = c;
            done_at   = -1;
            latch_cyc = -1;
        end else if (c == latch_cyc) begin
            n = expect_latch(int'(rv));
            busy_hi = c + n * T;
            done_at = c + 1 + n * T;
            dv_q.push_back('{c + 1, n});
            done_q.push_back('{done_at, n});
            latch_cyc = -1;
        end else if (st && !in_busy && c != done_at) begin
            busy_lo   = c + 1;
            busy_hi   = c + 2;
            latch_cyc = c + 2;
            change_q.push_back('{c + 1, 0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [17:0] rv);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rv);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the scoreboard every cycle.
    int dv_exp = 0;
    always @(negedge clk) begin
        bit exp_c;
        bit exp_d;
        bit exp_b;
        if (cyc >= mon_from) begin
            exp_c = (change_q.size() > 0) && (change_q[0].cyc == cyc);
            check("change", int'(change), int'(exp_c));
            if (exp_c) void'(change_q.pop_front());

            exp_d = (done_q.size() > 0) && (done_q[0].cyc == cyc);
            check("done", int'(done), int'(exp_d));
            if (exp_d) begin
                check("delay_at_done", int'(delay_value), done_q[0].val);
                void'(done_q.pop_front());
            end

            while (dv_q.size() > 0 && dv_q[0].cyc <= cyc) dv_exp = dv_q.pop_front().val;
            check("delay_value", int'(delay_value), dv_exp);

            exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
            check("busy", int'(busy), int'(exp_b));

            if (end_req && !final_done) begin
                check("pending_change", change_q.size(), 0);
                check("pending_done", done_q.size(), 0);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        logic [17:0] rv;
        drive(1'b0, 1'b0, 1'b1, 18'd0);
        drive(1'b0, 1'b0, 1'b1, 18'd0);
        idle(2, 18'd0);

        // Basic delay of 3 ticks.
        drive(1'b1, 1'b0, 1'b0, 18'd3);
        idle(20, 18'd3);

        // Zero delay.
        drive(1'b1, 1'b0, 1'b0, 18'd0);
        idle(10, 18'd0);

`ifdef RANDOM_DELAY_CLAMP_EN
        // Clamp low and high.
        drive(1'b1, 1'b0, 1'b0, 18'd1);
        idle(16, 18'd1);
        drive(1'b1, 1'b0, 1'b0, 18'd200000);
        idle(32, 18'd200000);
`endif

        // Cancel at cycle 8 of a 3-tick delay, then restart.
        drive(1'b1, 1'b0, 1'b0, 18'd3);
        idle(7, 18'd3);
        drive(1'b0, 1'b1, 1'b0, 18'd3);
        idle(3, 18'd3);
        drive(1'b1, 1'b0, 1'b0, 18'd3);
        idle(20, 18'd3);

        // Start while busy at cycles 2 and 6.
        drive(1'b1, 1'b0, 1'b0, 18'd3);
        idle(1, 18'd3);
        drive(1'b1, 1'b0, 1'b0, 18'd3);
        idle(3, 18'd3);
        drive(1'b1, 1'b0, 1'b0, 18'd3);
        idle(20, 18'd3);

        // Reset mid-COUNT at cycle 6.
        drive(1'b1, 1'b0, 1'b0, 18'd3);
        idle(5, 18'd3);
        drive(1'b0, 1'b0, 1'b1, 18'd3);
        idle(20, 18'd3);

        // Start sampled in DONE is ignored (zero delay: DONE at cycle 3).
        drive(1'b1, 1'b0, 1'b0, 18'd0);
        idle(2, 18'd0);
        drive(1'b1, 1'b0, 1'b0, 18'd0);
        idle(10, 18'd0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) rv = 18'($urandom_range(0, 262143));
            else rv = 18'($urandom_range(0, 7));
`ifndef RANDOM_DELAY_CLAMP_EN
            if (rv > 18'd7) rv = 18'd5;
`endif
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 199) == 0, rv);
        end
        idle(60, 18'd0);

        end_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
        if (!final_done) begin
            $display("FAIL monitor_end: got 0 expected 1");
            $fatal(1, "monitor did not finish");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
